// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one word per frame, shifted out MSB- or LSB-first.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_bar,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
`ifdef PISO_TX_PARITY_EN
        PARITY = 2'd2,
`endif
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             frame_start_q;
    logic             busy_q;
`ifdef PISO_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             first_bit_d;
    logic [WIDTH-1:0] load_d;
    logic             next_bit_d;
    logic [WIDTH-1:0] shift_d;

    // The bit on sout is always already removed from shreg_q, so the register holds only pending bits.
    always_comb begin
        first_bit_d = din[0];
        load_d      = {1'b0, din[WIDTH-1:1]};
        next_bit_d  = shreg_q[0];
        shift_d     = {1'b0, shreg_q[WIDTH-1:1]};
        if (MSB_FIRST) begin
            first_bit_d = din[WIDTH-1];
            load_d      = {din[WIDTH-2:0], 1'b0};
            next_bit_d  = shreg_q[WIDTH-1];
            shift_d     = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        state_q       <= SHIFT;
                        shreg_q       <= load_d;
                        cnt_q         <= '0;
                        sout_q        <= first_bit_d;
                        sout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b1;
                        busy_q        <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                        parity_q      <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    frame_start_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
`ifdef PISO_TX_PARITY_EN
                        state_q      <= PARITY;
                        sout_q       <= parity_q;
                        sout_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
`else
                        state_q      <= IDLE;
                        sout_q       <= 1'b0;
                        sout_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        shreg_q <= shift_d;
                        sout_q  <= next_bit_d;
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    state_q       <= IDLE;
                    sout_q        <= 1'b0;
                    sout_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    sout_q        <= 1'b0;
                    sout_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready   = (state_q == IDLE) && reset;
    assign sout        = sout_q;
    assign sout_bar    = ~sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a frame/bit-index reference model (parity aware via PISO_TX_PARITY_EN).
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         dinValid;

    logic mReady, mSout, mSoutBar, mValid, mStart, mBusy;
    logic lReady, lSout, lSoutBar, lValid, lStart, lBusy;

    int checks = 0;
    int errors = 0;

    // Reference model: whether a frame is on the line, its word, and which frame bit is shown now.
    bit           modelActive = 1'b0;
    logic [W-1:0] modelWord   = '0;
    int           modelIdx    = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) uMsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(dinValid), .din_ready(mReady),
        .sout(mSout), .sout_bar(mSoutBar), .sout_valid(mValid), .frame_start(mStart), .busy(mBusy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) uLsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(dinValid), .din_ready(lReady),
        .sout(lSout), .sout_bar(lSoutBar), .sout_valid(lValid), .frame_start(lStart), .busy(lBusy)
    );

    function automatic logic expBit(input logic [W-1:0] word, input int idx, input bit msbFirst);
        if (idx >= W) return ^word;
        return msbFirst ? word[W-1-idx] : word[idx];
    endfunction

    task automatic checkOne(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Compares both instances with the model after the latest clock edge.
    task automatic checkOutput();
        logic expM, expL;
        expM = modelActive ? expBit(modelWord, modelIdx, 1'b1) : 1'b0;
        expL = modelActive ? expBit(modelWord, modelIdx, 1'b0) : 1'b0;
        checkOne("msb.sout",        mSout,    expM);
        checkOne("msb.sout_bar",    mSoutBar, ~expM);
        checkOne("msb.sout_valid",  mValid,   modelActive);
        checkOne("msb.frame_start", mStart,   modelActive && (modelIdx == 0));
        checkOne("msb.busy",        mBusy,    modelActive);
        checkOne("msb.din_ready",   mReady,   !modelActive && reset);
        checkOne("lsb.sout",        lSout,    expL);
        checkOne("lsb.sout_bar",    lSoutBar, ~expL);
        checkOne("lsb.sout_valid",  lValid,   modelActive);
        checkOne("lsb.frame_start", lStart,   modelActive && (modelIdx == 0));
        checkOne("lsb.busy",        lBusy,    modelActive);
        checkOne("lsb.din_ready",   lReady,   !modelActive && reset);
    endtask

    // Applies one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic rstN, input logic valid, input logic [W-1:0] word);
        reset    = rstN;
        dinValid = valid;
        din      = word;
        @(posedge clk);
        if (!rstN) begin
            modelActive = 1'b0;
            modelIdx    = 0;
        end else if (!modelActive) begin
            if (valid) begin
                modelActive = 1'b1;
                modelWord   = word;
                modelIdx    = 0;
            end
        end else begin
            modelIdx++;
            if (modelIdx == FRAME_LEN) begin
                modelActive = 1'b0;
                modelIdx    = 0;
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, W'($urandom));
    endtask

    initial begin
        reset    = 1'b0;
        dinValid = 1'b0;
        din      = '0;

        $display("[TB] reset with din_valid asserted");
        applyStimulus(1'b0, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b1, 8'hC3);
        idleCycles(1);

        $display("[TB] single word 8'hA5");
        applyStimulus(1'b1, 1'b1, 8'hA5);
        idleCycles(FRAME_LEN + 2);

        $display("[TB] single word 8'h01");
        applyStimulus(1'b1, 1'b1, 8'h01);
        idleCycles(FRAME_LEN + 2);

        $display("[TB] words 8'h07 and 8'h03");
        applyStimulus(1'b1, 1'b1, 8'h07);
        idleCycles(FRAME_LEN + 1);
        applyStimulus(1'b1, 1'b1, 8'h03);
        idleCycles(FRAME_LEN + 1);

        $display("[TB] din_valid held: 8'hFF then 8'h00");
        applyStimulus(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < FRAME_LEN + 2; i++) applyStimulus(1'b1, 1'b1, 8'h00);
        idleCycles(FRAME_LEN + 2);

        $display("[TB] reset mid-frame of 8'hF0");
        applyStimulus(1'b1, 1'b1, 8'hF0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h77);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 8'h96);
        idleCycles(FRAME_LEN + 2);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), W'($urandom));
        end
        idleCycles(FRAME_LEN + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
